// File: rtl/tft_frame_engine_if.sv
// Pixel-write / screen-clear handshake plus video RAM bus shared between
// the frame engine (slave) and its surrounding logic and RAM (master).
interface tft_frame_engine_if #(
   parameter int COORD_W = 12,
   parameter int PW      = 9,
   parameter int ADDR_W  = 17
);
   logic               wr_req;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic [PW-1:0]      wr_data;
   logic               wr_ack;
   logic               clear_req;
   logic [PW-1:0]      clear_color;
   logic               clear_busy;
   logic               clear_done;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_waddr;
   logic [PW-1:0]      ram_wdata;
   logic [ADDR_W-1:0]  ram_raddr;
   logic [PW-1:0]      ram_rdata;

   modport master (
      output wr_req, wr_x, wr_y, wr_data, clear_req, clear_color, ram_rdata,
      input  wr_ack, clear_busy, clear_done, ram_we, ram_waddr, ram_wdata, ram_raddr
   );

   modport slave (
      input  wr_req, wr_x, wr_y, wr_data, clear_req, clear_color, ram_rdata,
      output wr_ack, clear_busy, clear_done, ram_we, ram_waddr, ram_wdata, ram_raddr
   );
endinterface

// File: rtl/tft_frame_engine.sv
// TFT panel engine: scan timing, video RAM readout to the panel pins, and
// arbitration of touch-path pixel writes against a self-running screen clear.
module tft_frame_engine #(
   parameter int X_RES          = 480,
   parameter int Y_RES          = 272,
   parameter int X_BLANK        = 45,
   parameter int Y_BLANK        = 16,
   parameter int CLK_DIV        = 5,
   parameter int BITS_PER_COLOR = 3,
   parameter int COORD_W        = 12,
   parameter int ADDR_W         = 17
) (
   input  logic               cclk,
   input  logic               rstb,
   tft_frame_engine_if.slave  bus,
   output logic               tft_vdd,
   output logic               tft_display,
   output logic               tft_backlight,
   output logic               tft_data_ena,
   output logic [7:0]         tft_red,
   output logic [7:0]         tft_green,
   output logic [7:0]         tft_blue,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               new_frame
);
   localparam int BPC   = BITS_PER_COLOR;
   localparam int PW    = 3 * BPC;
   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(X_RES + X_BLANK - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(Y_RES + Y_BLANK - 1);
   localparam logic [COORD_W-1:0] X_ACT     = COORD_W'(X_RES);
   localparam logic [COORD_W-1:0] Y_ACT     = COORD_W'(Y_RES);
   localparam logic [ADDR_W-1:0]  X_RES_A   = ADDR_W'(X_RES);
   localparam logic [ADDR_W-1:0]  CLEAR_END = ADDR_W'(X_RES * Y_RES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [DIV_W-1:0]   div_q, div_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               tick, xWrap, frameWrap, active;
   logic               act1_q, ena_q, vdd_q, disp_q;
   logic [7:0]         red_q, green_q, blue_q;
   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  c_q, c_d;
   logic [PW-1:0]      color_q, color_d;
   logic               inRange, wrAck, ramWe, clearBusy, clearDone;
   logic [ADDR_W-1:0]  ramWaddr, wrAddr;
   logic [PW-1:0]      ramWdata;

   assign tick      = (div_q == DIV_LAST);
   assign xWrap     = tick && (x_q == X_LAST);
   assign frameWrap = xWrap && (y_q == Y_LAST);
   assign active    = (x_q < X_ACT) && (y_q < Y_ACT);

   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      x_d   = x_q;
      y_d   = y_q;
      if (tick) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
         end else begin
            x_d = x_q + COORD_W'(1);
         end
      end
   end

   assign wrAddr  = ADDR_W'(bus.wr_y) * X_RES_A + ADDR_W'(bus.wr_x);
   assign inRange = (bus.wr_x < X_ACT) && (bus.wr_y < Y_ACT);

   // Clear wins over a same-cycle write; writes are stalled until back in IDLE.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      color_d   = color_q;
      wrAck     = 1'b0;
      ramWe     = 1'b0;
      ramWaddr  = '0;
      ramWdata  = '0;
      clearBusy = 1'b0;
      clearDone = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_d = ST_CLEAR;
               c_d     = '0;
               color_d = bus.clear_color;
            end else if (bus.wr_req) begin
               wrAck = 1'b1;
               if (inRange) begin
                  ramWe    = 1'b1;
                  ramWaddr = wrAddr;
                  ramWdata = bus.wr_data;
               end
            end
         end
         ST_CLEAR: begin
            clearBusy = 1'b1;
            ramWe     = 1'b1;
            ramWaddr  = c_q;
            ramWdata  = color_q;
            if (c_q == CLEAR_END) begin
               state_d = ST_DONE;
               c_d     = '0;
            end else begin
               c_d = c_q + ADDR_W'(1);
            end
         end
         ST_DONE: begin
            clearDone = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rstb) begin
         wrAck     = 1'b0;
         ramWe     = 1'b0;
         ramWaddr  = '0;
         ramWdata  = '0;
         clearBusy = 1'b0;
         clearDone = 1'b0;
      end
   end

   // Two-stage readout: the RAM itself supplies one cycle, the RGB register the other.
   always_ff @(posedge cclk) begin
      if (rstb) begin
         div_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         act1_q  <= 1'b0;
         ena_q   <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         vdd_q   <= 1'b0;
         disp_q  <= 1'b0;
         state_q <= ST_IDLE;
         c_q     <= '0;
         color_q <= '0;
      end else begin
         div_q   <= div_d;
         x_q     <= x_d;
         y_q     <= y_d;
         act1_q  <= active;
         ena_q   <= act1_q;
         red_q   <= act1_q ? (8'(bus.ram_rdata[PW-1 -: BPC]) << (8 - BPC)) : 8'd0;
         green_q <= act1_q ? (8'(bus.ram_rdata[2*BPC-1 -: BPC]) << (8 - BPC)) : 8'd0;
         blue_q  <= act1_q ? (8'(bus.ram_rdata[BPC-1:0]) << (8 - BPC)) : 8'd0;
         vdd_q   <= 1'b1;
         disp_q  <= disp_q | frameWrap;
         state_q <= state_d;
         c_q     <= c_d;
         color_q <= color_d;
      end
   end

   assign bus.ram_raddr  = active ? ADDR_W'(y_q) * X_RES_A + ADDR_W'(x_q) : '0;
   assign bus.wr_ack     = wrAck;
   assign bus.ram_we     = ramWe;
   assign bus.ram_waddr  = ramWaddr;
   assign bus.ram_wdata  = ramWdata;
   assign bus.clear_busy = clearBusy;
   assign bus.clear_done = clearDone;

   assign new_frame     = frameWrap && !rstb;
   assign tft_vdd       = vdd_q;
   assign tft_display   = disp_q;
   assign tft_backlight = disp_q;
   assign tft_data_ena  = ena_q;
   assign tft_red       = red_q;
   assign tft_green     = green_q;
   assign tft_blue      = blue_q;
   assign x             = x_q;
   assign y             = y_q;
endmodule

// File: tb/tb_tft_frame_engine.sv
// Directed bench for tft_frame_engine on a tiny 8x4 panel with a behavioural
// synchronous-read video RAM.
module tb_tft_frame_engine;
   logic        cclk = 1'b0;
   logic        rstb = 1'b1;
   logic        tft_vdd, tft_display, tft_backlight, tft_data_ena, new_frame;
   logic [7:0]  tft_red, tft_green, tft_blue;
   logic [11:0] x, y;
   logic [8:0]  mem [0:31];
   int          checks = 0;
   int          errors = 0;

   tft_frame_engine_if #(.COORD_W(12), .PW(9), .ADDR_W(17)) bus ();

   tft_frame_engine #(
      .X_RES(8), .Y_RES(4), .X_BLANK(2), .Y_BLANK(1), .CLK_DIV(3),
      .BITS_PER_COLOR(3), .COORD_W(12), .ADDR_W(17)
   ) dut (
      .cclk(cclk), .rstb(rstb), .bus(bus),
      .tft_vdd(tft_vdd), .tft_display(tft_display), .tft_backlight(tft_backlight),
      .tft_data_ena(tft_data_ena), .tft_red(tft_red), .tft_green(tft_green),
      .tft_blue(tft_blue), .x(x), .y(y), .new_frame(new_frame)
   );

   always #5 cclk = ~cclk;

   // Video RAM model: write port and registered read port.
   always @(posedge cclk) begin
      if (bus.ram_we) mem[bus.ram_waddr[4:0]] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_raddr[4:0]];
   end

   task automatic step();
      @(negedge cclk);
   endtask

   task automatic runClear(input int pulseAt, input logic [8:0] color,
                           output int nBusy, output int nDone, output int doneAt,
                           output int ackAt, output int badWrites, output logic [16:0] ackAddr);
      nBusy = 0; nDone = 0; doneAt = -1; ackAt = -1; badWrites = 0; ackAddr = '0;
      for (int i = 1; i <= 60 && ackAt < 0; i++) begin
         step();
         if (i == 1) begin
            bus.clear_req = 1'b0; bus.clear_color = 9'h000;
            bus.wr_req = 1'b1; bus.wr_x = 12'd5; bus.wr_y = 12'd1; bus.wr_data = 9'h155;
         end
         if (i == pulseAt) bus.clear_req = 1'b1;
         if (i == pulseAt + 1) bus.clear_req = 1'b0;
         #1;
         if (bus.clear_busy) begin
            if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 17'(nBusy) ||
                bus.ram_wdata !== color || bus.wr_ack !== 1'b0) badWrites++;
            nBusy++;
         end
         if (bus.clear_done) begin nDone++; doneAt = i; end
         if (bus.wr_ack) begin ackAt = i; ackAddr = bus.ram_waddr; end
      end
      step();
      bus.wr_req = 1'b0;
   endtask

   task automatic test_reset();
      bus.wr_req = 1'b1; bus.wr_x = 12'd1; bus.wr_y = 12'd1; bus.wr_data = 9'h1FF;
      bus.clear_req = 1'b0; bus.clear_color = 9'h000;
      repeat (3) step();
      #1;
      checks++; if (x !== 12'd0 || y !== 12'd0) begin errors++; $display("[TB] FAIL reset_xy: got %0d,%0d expected 0,0", x, y); end
      checks++; if (tft_vdd !== 1'b0 || tft_display !== 1'b0 || tft_backlight !== 1'b0) begin errors++; $display("[TB] FAIL reset_power: got %b%b%b expected 000", tft_vdd, tft_display, tft_backlight); end
      checks++; if (bus.wr_ack !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got ack=%b we=%b expected 0,0", bus.wr_ack, bus.ram_we); end
      checks++; if (tft_data_ena !== 1'b0 || tft_red !== 8'h00 || bus.clear_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_panel: got ena=%b red=%h busy=%b expected 0", tft_data_ena, tft_red, bus.clear_busy); end
      step();
      rstb = 1'b0; bus.wr_req = 1'b0;
   endtask

   task automatic test_timing();
      int first = -1, second = -1, enaCount = 0;
      for (int i = 0; i < 400 && second < 0; i++) begin
         step(); #1;
         if (first >= 0 && tft_data_ena) enaCount++;
         if (first >= 0 && i == first + 1) begin
            checks++; if (tft_display !== 1'b1 || tft_backlight !== 1'b1) begin errors++; $display("[TB] FAIL display_rise: got %b%b expected 11", tft_display, tft_backlight); end
         end
         if (new_frame) begin
            if (first < 0) begin
               first = i;
               checks++; if (tft_display !== 1'b0) begin errors++; $display("[TB] FAIL display_early: got %b expected 0", tft_display); end
            end else second = i;
         end
      end
      checks++; if (second - first !== 150 || first < 0) begin errors++; $display("[TB] FAIL frame_period: got %0d expected 150", second - first); end
      checks++; if (enaCount !== 96) begin errors++; $display("[TB] FAIL ena_count: got %0d expected 96", enaCount); end
      checks++; if (tft_vdd !== 1'b1) begin errors++; $display("[TB] FAIL vdd_on: got %b expected 1", tft_vdd); end
   endtask

   task automatic test_write();
      bit found = 0;
      step();
      bus.wr_req = 1'b1; bus.wr_x = 12'd3; bus.wr_y = 12'd2; bus.wr_data = 9'h1C7;
      #1;
      checks++; if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b1) begin errors++; $display("[TB] FAIL write_ack: got ack=%b we=%b expected 1,1", bus.wr_ack, bus.ram_we); end
      checks++; if (bus.ram_waddr !== 17'd19 || bus.ram_wdata !== 9'h1C7) begin errors++; $display("[TB] FAIL write_addr: got %0d/%h expected 19/1c7", bus.ram_waddr, bus.ram_wdata); end
      step();
      bus.wr_req = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin step(); #1; if (x == 12'd2 && y == 12'd2) found = 1; end
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin step(); #1; if (x == 12'd3) found = 1; end
      checks++; if (!found) begin errors++; $display("[TB] FAIL scan_find: got no pixel (3,2) expected one"); end
      step(); #1;
      checks++; if (tft_red !== 8'h00 || tft_data_ena !== 1'b1) begin errors++; $display("[TB] FAIL pixel_lag: got red=%h ena=%b expected 00,1", tft_red, tft_data_ena); end
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         checks++; if (tft_red !== 8'hE0 || tft_green !== 8'h00 || tft_blue !== 8'hE0) begin errors++; $display("[TB] FAIL pixel_rgb: got %h %h %h expected e0 00 e0", tft_red, tft_green, tft_blue); end
      end
      step(); #1;
      checks++; if (tft_red !== 8'h00 || tft_blue !== 8'h00) begin errors++; $display("[TB] FAIL pixel_next: got %h %h expected 00 00", tft_red, tft_blue); end
   endtask

   task automatic test_out_of_range();
      step();
      bus.wr_req = 1'b1; bus.wr_x = 12'd8; bus.wr_y = 12'd0; bus.wr_data = 9'h0AA;
      #1;
      checks++; if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_x: got ack=%b we=%b expected 1,0", bus.wr_ack, bus.ram_we); end
      step();
      bus.wr_x = 12'd0; bus.wr_y = 12'd4;
      #1;
      checks++; if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL oor_y: got ack=%b we=%b expected 1,0", bus.wr_ack, bus.ram_we); end
      step();
      bus.wr_x = 12'd7; bus.wr_y = 12'd3;
      #1;
      checks++; if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 17'd31) begin errors++; $display("[TB] FAIL corner_write: got we=%b addr=%0d expected 1,31", bus.ram_we, bus.ram_waddr); end
      step();
      bus.wr_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      step();
      bus.wr_req = 1'b1; bus.wr_x = 12'd0; bus.wr_y = 12'd0; bus.wr_data = 9'h111;
      #1;
      checks++; if (bus.wr_ack !== 1'b1 || bus.ram_waddr !== 17'd0) begin errors++; $display("[TB] FAIL b2b_first: got ack=%b addr=%0d expected 1,0", bus.wr_ack, bus.ram_waddr); end
      step();
      bus.wr_x = 12'd1; bus.wr_data = 9'h122;
      #1;
      checks++; if (bus.wr_ack !== 1'b1 || bus.ram_waddr !== 17'd1 || bus.ram_wdata !== 9'h122) begin errors++; $display("[TB] FAIL b2b_second: got ack=%b addr=%0d data=%h expected 1,1,122", bus.wr_ack, bus.ram_waddr, bus.ram_wdata); end
      step();
      bus.wr_req = 1'b0;
      #1;
      checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release: got ack=%b expected 0", bus.wr_ack); end
   endtask

   task automatic test_clear();
      int nBusy, nDone, doneAt, ackAt, bad;
      logic [16:0] ackAddr;
      step();
      bus.clear_req = 1'b1; bus.clear_color = 9'h03F;
      #1;
      checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_start: got busy=%b expected 0", bus.clear_busy); end
      runClear(100, 9'h03F, nBusy, nDone, doneAt, ackAt, bad, ackAddr);
      checks++; if (nBusy !== 32 || bad !== 0) begin errors++; $display("[TB] FAIL clear_writes: got %0d writes %0d bad expected 32 writes 0 bad", nBusy, bad); end
      checks++; if (nDone !== 1 || doneAt !== 33) begin errors++; $display("[TB] FAIL clear_done: got %0d pulses at %0d expected 1 at 33", nDone, doneAt); end
      checks++; if (ackAt !== 34 || ackAddr !== 17'd13) begin errors++; $display("[TB] FAIL clear_stall: got ack at %0d addr %0d expected 34 addr 13", ackAt, ackAddr); end
   endtask

   task automatic test_collision();
      int nBusy, nDone, doneAt, ackAt, bad;
      logic [16:0] ackAddr;
      step();
      bus.clear_req = 1'b1; bus.clear_color = 9'h1C0;
      bus.wr_req = 1'b1; bus.wr_x = 12'd2; bus.wr_y = 12'd0; bus.wr_data = 9'h0F0;
      #1;
      checks++; if (bus.wr_ack !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL collide_ack: got ack=%b we=%b expected 0,0", bus.wr_ack, bus.ram_we); end
      runClear(10, 9'h1C0, nBusy, nDone, doneAt, ackAt, bad, ackAddr);
      checks++; if (nBusy !== 32 || bad !== 0) begin errors++; $display("[TB] FAIL collide_writes: got %0d writes %0d bad expected 32 writes 0 bad", nBusy, bad); end
      checks++; if (doneAt !== 33 || ackAt !== 34) begin errors++; $display("[TB] FAIL collide_timing: got done %0d ack %0d expected 33,34", doneAt, ackAt); end
   endtask

   task automatic test_reset_mid_clear();
      bit hit = 0;
      int seen = 0;
      step();
      bus.clear_req = 1'b1; bus.clear_color = 9'h077;
      step();
      bus.clear_req = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         #1;
         if (bus.clear_busy && bus.ram_waddr == 17'd10) begin rstb = 1'b1; hit = 1; end
         else step();
      end
      checks++; if (!hit) begin errors++; $display("[TB] FAIL abort_find: got no c=10 expected one"); end
      step(); #1;
      checks++; if (bus.ram_we !== 1'b0 || bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_write: got we=%b busy=%b done=%b expected 0", bus.ram_we, bus.clear_busy, bus.clear_done); end
      checks++; if (tft_vdd !== 1'b0 || tft_display !== 1'b0 || x !== 12'd0 || tft_data_ena !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs: got vdd=%b disp=%b x=%0d ena=%b expected 0", tft_vdd, tft_display, x, tft_data_ena); end
      step();
      rstb = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(); #1;
         if (bus.clear_done || bus.clear_busy || bus.ram_we) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", seen); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 9'h000;
      test_reset();
      test_timing();
      test_write();
      test_out_of_range();
      test_back_to_back();
      test_clear();
      test_collision();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
